alu_issue: RTL and testbench
============================

Name: alu_issue

Overview:
- Instruction issue and writeback stage placed directly upstream of the 8-bit, 4-bit-ctrl ALU.
- Accepts 16-bit instructions over a valid/ready handshake and reads the source operands from an internal 8x8 register file.
- Drives registered ctrl/x/y to the ALU, then writes the ALU result and carry back to the register file and reports it on a result port.
- One instruction in flight at a time; throughput is one instruction per 2 cycles.

Parameters:
- DATA_W, 8, register and ALU data width. Only 8 is supported.
- NREG, 8, number of registers. Must match the 3-bit register fields.
- INSTR_W, 16, instruction width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  instruction valid.
- in_ready  out  1  stage can accept an instruction.
- in_instr  in  16  fields: [15:12] op, [11:9] rd, [8:6] rs1, [5:3] rs2, [7:0] imm (LDI only).
- alu_ctrl  out  4  to ALU ctrl.
- alu_x  out  8  to ALU x.
- alu_y  out  8  to ALU y.
- alu_out  in  8  from ALU out.
- alu_carry  in  1  from ALU carry.
- res_valid  out  1  one-cycle pulse: instruction retired.
- res_rd  out  3  destination register of the retired instruction.
- res_data  out  8  value written, or 0 on error.
- res_carry  out  1  carry flag after retirement.
- res_err  out  1  retired instruction had an illegal op.
- dbg_addr  in  3  debug read address.
- dbg_data  out  8  regfile[dbg_addr], combinational.

Behaviour:
- Reset (async, rst_n=0):
  - All 8 registers = 0; carry flag = 0; state = IDLE.
  - alu_ctrl/alu_x/alu_y = 0.
  - res_valid = 0, res_rd = 0, res_data = 0, res_carry = 0, res_err = 0.
  - An in-flight instruction is discarded with no writeback.
- FSM states: IDLE, EXEC. in_ready = (state==IDLE).
- IDLE:
  - Accept on in_valid & in_ready at the rising edge.
  - At that edge: alu_ctrl <= op, alu_x <= R[rs1], alu_y <= R[rs2]; latch rd/op/imm; go to EXEC.
- EXEC (exactly 1 cycle, the ALU is combinational):
  - At the end edge, write back per op and return to IDLE.
  - res_* are registered and valid in the cycle after EXEC; res_valid is high for exactly 1 cycle.
- Op 0-12 (ALU ops):
  - R[rd] <= alu_out; carry flag <= alu_carry. Carry is 0 for non-arithmetic ops, as the ALU produces it.
  - res_data = alu_out, res_err = 0.
- Op 15 (LDI):
  - R[rd] <= imm; carry flag unchanged; res_data = imm.
  - alu_ctrl is still driven with 15; alu_out is ignored.
- Op 13, 14 (illegal): no register write, carry unchanged, res_data = 0, res_err = 1.
- Hazards:
  - No overlap between issue and writeback, so no bypass is needed.
  - A back-to-back dependent instruction is accepted in the IDLE cycle after EXEC and reads the updated value.
- rd == rs1 or rd == rs2: operands are read at issue, and the write occurs at the EXEC edge.
- in_valid held high during EXEC: the instruction is not accepted; the source holds it until in_ready.
- in_instr is sampled only at the accept edge.
- dbg_data reflects a write from the cycle after the writeback edge.

Decomposition:
- Shared package alu_pkg:
  - Opcode constants OP_ADD..OP_EQ (0-12), OP_LDI (15).
  - State encoding IDLE/EXEC.
  - Field position constants for op/rd/rs1/rs2/imm.
- One sub-module, alu_regfile: 8x8, two combinational read ports plus a debug read port, one synchronous write port, async active-low reset to 0.

Test Plan:
- Reset, then LDI r1=0xF0, LDI r2=0x20:
  - Each retirement shows res_valid 2 cycles after accept; res_data=0xF0, then 0x20.
  - in_ready is low during EXEC.
- ADD r3,r1,r2 -> alu_x=0xF0, alu_y=0x20, res_data=0x10, res_carry=1; dbg_addr=3 reads 0x10.
- SUB r4,r2,r1 -> res_data=0x30, res_carry=1.
- Then OR r5,r1,r2 -> res_data=0xF0, res_carry=0.
- LDI r6=0x03, LDI r7=0x81, then ctrl 7 (shift left) r0,r6,r7 -> res_data=0x08 (0x81<<3).
- Then ctrl 12 (equal) r0,r1,r1 -> res_data=0x01.
- op 13 with rd=1 -> res_err=1, res_data=0.
  - r1 still 0xF0; carry unchanged.
  - in_valid held continuously through 3 instructions: exactly one accept per 2 cycles.
- Assert rst_n=0 mid-EXEC of ADD r3 (r3 preloaded 0x55):
  - All outputs 0 immediately; r3 reads 0; no res_valid pulse.
  - First accept after reset release behaves normally.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared constants and types for the ALU issue/writeback stage.
// Holds widths, instruction field positions, opcodes and the FSM state type.
package alu_pkg;

    localparam int DATA_W  = 8;
    localparam int NREG    = 8;
    localparam int INSTR_W = 16;
    localparam int REG_W   = 3;
    localparam int OP_W    = 4;

    localparam int OP_LSB  = 12;
    localparam int RD_LSB  = 9;
    localparam int RS1_LSB = 6;
    localparam int RS2_LSB = 3;
    localparam int IMM_LSB = 0;

    localparam logic [OP_W-1:0] OP_ADD  = 4'd0;
    localparam logic [OP_W-1:0] OP_SUB  = 4'd1;
    localparam logic [OP_W-1:0] OP_AND  = 4'd2;
    localparam logic [OP_W-1:0] OP_OR   = 4'd3;
    localparam logic [OP_W-1:0] OP_XOR  = 4'd4;
    localparam logic [OP_W-1:0] OP_NOT  = 4'd5;
    localparam logic [OP_W-1:0] OP_NAND = 4'd6;
    localparam logic [OP_W-1:0] OP_SHL  = 4'd7;
    localparam logic [OP_W-1:0] OP_SHR  = 4'd8;
    localparam logic [OP_W-1:0] OP_INC  = 4'd9;
    localparam logic [OP_W-1:0] OP_DEC  = 4'd10;
    localparam logic [OP_W-1:0] OP_LT   = 4'd11;
    localparam logic [OP_W-1:0] OP_EQ   = 4'd12;
    localparam logic [OP_W-1:0] OP_LDI  = 4'd15;

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_e;

    // Opcodes 13 and 14 are unassigned and retire as errors.
    function automatic logic is_illegal(input logic [OP_W-1:0] op);
        return (op == 4'd13) || (op == 4'd14);
    endfunction

endpackage

// File: rtl/alu_issue_if.sv
// alu_issue_if: instruction handshake and retirement report bundle.
// master = instruction source / result sink, slave = the issue stage.
interface alu_issue_if;
    import alu_pkg::*;

    logic               in_valid;
    logic               in_ready;
    logic [INSTR_W-1:0] in_instr;

    logic               res_valid;
    logic [REG_W-1:0]   res_rd;
    logic [DATA_W-1:0]  res_data;
    logic               res_carry;
    logic               res_err;

    modport master (
        output in_valid, in_instr,
        input  in_ready,
        input  res_valid, res_rd, res_data, res_carry, res_err
    );

    modport slave (
        input  in_valid, in_instr,
        output in_ready,
        output res_valid, res_rd, res_data, res_carry, res_err
    );

endinterface

// File: rtl/alu_regfile.sv
// alu_regfile: 8x8 register file, two async read ports, one debug read,
// one synchronous write port; async active-low reset clears all entries.
module alu_regfile
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_W-1:0]  ra1,
    input  logic [REG_W-1:0]  ra2,
    input  logic [REG_W-1:0]  dbg_addr,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    output logic [DATA_W-1:0] dbg_data,
    input  logic              we,
    input  logic [REG_W-1:0]  wa,
    input  logic [DATA_W-1:0] wd
);

    logic [DATA_W-1:0] mem [NREG];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[wa] <= wd;
        end
    end

    assign rd1      = mem[ra1];
    assign rd2      = mem[ra2];
    assign dbg_data = mem[dbg_addr];

endmodule

// File: rtl/alu_issue.sv
// alu_issue: issue/writeback stage in front of an external combinational ALU.
// Ports: clk, rst_n, io (handshake + result), alu_ctrl/x/y/out/carry, dbg_*.
module alu_issue
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    alu_issue_if.slave        io,
    output logic [OP_W-1:0]   alu_ctrl,
    output logic [DATA_W-1:0] alu_x,
    output logic [DATA_W-1:0] alu_y,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_carry,
    input  logic [REG_W-1:0]  dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    state_e            state;
    state_e            state_nx;
    logic              accept;
    logic              wr_en;
    logic              carry_q;
    logic              carry_nx;
    logic [OP_W-1:0]   op_q;
    logic [REG_W-1:0]  rd_q;
    logic [DATA_W-1:0] imm_q;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] rs1_data;
    logic [DATA_W-1:0] rs2_data;

    logic [OP_W-1:0]   f_op;
    logic [REG_W-1:0]  f_rd;
    logic [REG_W-1:0]  f_rs1;
    logic [REG_W-1:0]  f_rs2;
    logic [DATA_W-1:0] f_imm;

    assign f_op  = io.in_instr[OP_LSB  +: OP_W];
    assign f_rd  = io.in_instr[RD_LSB  +: REG_W];
    assign f_rs1 = io.in_instr[RS1_LSB +: REG_W];
    assign f_rs2 = io.in_instr[RS2_LSB +: REG_W];
    assign f_imm = io.in_instr[IMM_LSB +: DATA_W];

    alu_regfile u_rf (
        .clk      (clk),
        .rst_n    (rst_n),
        .ra1      (f_rs1),
        .ra2      (f_rs2),
        .dbg_addr (dbg_addr),
        .rd1      (rs1_data),
        .rd2      (rs2_data),
        .dbg_data (dbg_data),
        .we       (wr_en),
        .wa       (rd_q),
        .wd       (wr_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx    = state;
        io.in_ready = 1'b0;
        accept      = 1'b0;
        wr_en       = 1'b0;
        unique case (state)
            IDLE: begin
                io.in_ready = 1'b1;
                accept      = io.in_valid;
                if (io.in_valid) state_nx = EXEC;
            end
            EXEC: begin
                wr_en    = !is_illegal(op_q);
                state_nx = IDLE;
            end
        endcase
    end

    // LDI bypasses the ALU result and keeps the carry;
    // illegal ops report zero and keep the carry.
    always_comb begin
        wr_data  = alu_out;
        carry_nx = carry_q;
        unique case (1'b1)
            (op_q == OP_LDI):  wr_data = imm_q;
            is_illegal(op_q):  wr_data = '0;
            default:           carry_nx = alu_carry;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_ctrl     <= '0;
            alu_x        <= '0;
            alu_y        <= '0;
            op_q         <= '0;
            rd_q         <= '0;
            imm_q        <= '0;
            carry_q      <= 1'b0;
            io.res_valid <= 1'b0;
            io.res_rd    <= '0;
            io.res_data  <= '0;
            io.res_carry <= 1'b0;
            io.res_err   <= 1'b0;
        end else begin
            io.res_valid <= 1'b0;
            if (accept) begin
                alu_ctrl <= f_op;
                alu_x    <= rs1_data;
                alu_y    <= rs2_data;
                op_q     <= f_op;
                rd_q     <= f_rd;
                imm_q    <= f_imm;
            end
            if (state == EXEC) begin
                carry_q      <= carry_nx;
                io.res_valid <= 1'b1;
                io.res_rd    <= rd_q;
                io.res_data  <= wr_data;
                io.res_carry <= carry_nx;
                io.res_err   <= is_illegal(op_q);
            end
        end
    end

endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: directed plus random instructions for alu_issue, checked
// against a register-array model and a behavioural stand-in ALU.
module tb_alu_issue;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] alu_ctrl;
    logic [7:0] alu_x;
    logic [7:0] alu_y;
    logic [7:0] alu_out;
    logic       alu_carry;
    logic [2:0] dbg_addr;
    logic [7:0] dbg_data;

    int checks = 0;
    int errors = 0;

    logic [7:0] m [8];
    logic       mc;

    alu_issue_if io ();

    alu_issue dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .io        (io),
        .alu_ctrl  (alu_ctrl),
        .alu_x     (alu_x),
        .alu_y     (alu_y),
        .alu_out   (alu_out),
        .alu_carry (alu_carry),
        .dbg_addr  (dbg_addr),
        .dbg_data  (dbg_data)
    );

    always #5 clk = ~clk;

    // {carry, out} of the downstream ALU for each ctrl value.
    function automatic logic [8:0] alu_fn(input logic [3:0] op,
                                          input logic [7:0] x,
                                          input logic [7:0] y);
        logic [8:0] r;
        r = '0;
        case (op)
            4'd0:  r = {1'b0, x} + {1'b0, y};
            4'd1:  r = {1'b0, x} - {1'b0, y};
            4'd2:  r = {1'b0, x & y};
            4'd3:  r = {1'b0, x | y};
            4'd4:  r = {1'b0, x ^ y};
            4'd5:  r = {1'b0, ~x};
            4'd6:  r = {1'b0, ~(x & y)};
            4'd7:  r = {1'b0, 8'(y << x[2:0])};
            4'd8:  r = {1'b0, 8'(y >> x[2:0])};
            4'd9:  r = {1'b0, x} + 9'd1;
            4'd10: r = {1'b0, x} - 9'd1;
            4'd11: r = {8'd0, (x < y)};
            4'd12: r = {8'd0, (x == y)};
            default: r = '0;
        endcase
        return r;
    endfunction

    assign {alu_carry, alu_out} = alu_fn(alu_ctrl, alu_x, alu_y);

    function automatic logic [15:0] mk(input int op, input int rd,
                                       input int rs1, input int rs2);
        return {op[3:0], rd[2:0], rs1[2:0], rs2[2:0], 3'b000};
    endfunction

    function automatic logic [15:0] ldi(input int rd, input int imm);
        return {4'hF, rd[2:0], 1'b0, imm[7:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m[i] = 8'h00;
        mc = 1'b0;
    endtask

    // Called just after the retire edge; checks res_* and updates model.
    task automatic retire_check(input logic [15:0] ins);
        logic [3:0] op;
        logic [2:0] rd;
        logic [8:0] r;
        logic [7:0] ed;
        logic       ec;
        logic       ee;
        op = ins[15:12];
        rd = ins[11:9];
        ec = mc;
        ee = 1'b0;
        ed = 8'h00;
        if (op <= 4'd12) begin
            r  = alu_fn(op, m[ins[8:6]], m[ins[5:3]]);
            ed = r[7:0];
            ec = r[8];
        end else if (op == 4'd15) begin
            ed = ins[7:0];
        end else begin
            ee = 1'b1;
        end
        chk("res_valid", io.res_valid, 1);
        chk("res_rd", io.res_rd, rd);
        chk("res_data", io.res_data, ed);
        chk("res_carry", io.res_carry, ec);
        chk("res_err", io.res_err, ee);
        if (!ee) m[rd] = ed;
        mc = ec;
        dbg_addr = rd;
        #1;
        chk("dbg_wb", dbg_data, m[rd]);
    endtask

    // Starts and ends at a falling edge.
    task automatic issue(input logic [15:0] ins);
        int n;
        n = 0;
        while (!io.in_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", io.in_ready, 1);
        io.in_valid = 1'b1;
        io.in_instr = ins;
        @(posedge clk);
        #1;
        io.in_valid = 1'b0;
        io.in_instr = 16'($urandom);
        chk("exec_ready", io.in_ready, 0);
        chk("exec_rvalid", io.res_valid, 0);
        chk("alu_ctrl", alu_ctrl, ins[15:12]);
        chk("alu_x", alu_x, m[ins[8:6]]);
        chk("alu_y", alu_y, m[ins[5:3]]);
        @(posedge clk);
        #1;
        retire_check(ins);
        @(negedge clk);
    endtask

    // in_valid stays high across three instructions.
    task automatic stream3(input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] c);
        logic [15:0] s [3];
        int k;
        s[0] = a;
        s[1] = b;
        s[2] = c;
        k = 0;
        io.in_valid = 1'b1;
        io.in_instr = s[0];
        for (int cyc = 0; cyc < 6; cyc++) begin
            chk("strm_ready", io.in_ready, (cyc % 2 == 0) ? 1 : 0);
            @(posedge clk);
            #1;
            if (cyc % 2 == 1) begin
                retire_check(s[k]);
                k++;
                if (k < 3) io.in_instr = s[k];
                else       io.in_valid = 1'b0;
            end else begin
                chk("strm_ctrl", alu_ctrl, s[k][15:12]);
                chk("strm_rvalid", io.res_valid, 0);
            end
            @(negedge clk);
        end
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_ready"}, io.in_ready, 1);
        chk({tag, "_ctrl"}, alu_ctrl, 0);
        chk({tag, "_x"}, alu_x, 0);
        chk({tag, "_y"}, alu_y, 0);
        chk({tag, "_rvalid"}, io.res_valid, 0);
        chk({tag, "_rd"}, io.res_rd, 0);
        chk({tag, "_rdata"}, io.res_data, 0);
        chk({tag, "_rcarry"}, io.res_carry, 0);
        chk({tag, "_rerr"}, io.res_err, 0);
    endtask

    initial begin
        io.in_valid = 1'b0;
        io.in_instr = 16'h0000;
        dbg_addr    = 3'd0;
        model_reset();

        repeat (2) @(negedge clk);
        chk_outputs_zero("rst");
        for (int i = 0; i < 8; i++) begin
            dbg_addr = 3'(i);
            #1;
            chk("rst_reg", dbg_data, 0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        issue(ldi(1, 8'hF0));
        chk("p_ldi1", io.res_data, 8'hF0);
        issue(ldi(2, 8'h20));
        chk("p_ldi2", io.res_data, 8'h20);

        issue(mk(0, 3, 1, 2));
        chk("p_add_x", alu_x, 8'hF0);
        chk("p_add_y", alu_y, 8'h20);
        chk("p_add", io.res_data, 8'h10);
        chk("p_add_c", io.res_carry, 1);
        dbg_addr = 3'd3;
        #1;
        chk("p_dbg3", dbg_data, 8'h10);

        issue(mk(1, 4, 2, 1));
        chk("p_sub", io.res_data, 8'h30);
        chk("p_sub_c", io.res_carry, 1);
        issue(mk(3, 5, 1, 2));
        chk("p_or", io.res_data, 8'hF0);
        chk("p_or_c", io.res_carry, 0);

        issue(ldi(6, 8'h03));
        issue(ldi(7, 8'h81));
        issue(mk(7, 0, 6, 7));
        chk("p_shl", io.res_data, 8'h08);
        issue(mk(12, 0, 1, 1));
        chk("p_eq", io.res_data, 8'h01);

        issue(mk(0, 3, 1, 2));
        issue(mk(13, 1, 0, 0));
        chk("p_ill_err", io.res_err, 1);
        chk("p_ill_data", io.res_data, 0);
        chk("p_ill_c", io.res_carry, 1);
        dbg_addr = 3'd1;
        #1;
        chk("p_ill_r1", dbg_data, 8'hF0);

        stream3(mk(4, 2, 1, 5), mk(9, 3, 2, 0), mk(0, 4, 3, 3));

        for (int t = 0; t < 40; t++) begin
            issue({4'($urandom_range(0, 15)), 12'($urandom)});
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        issue(ldi(3, 8'h55));
        issue(ldi(1, 8'hF0));
        io.in_valid = 1'b1;
        io.in_instr = mk(0, 3, 1, 2);
        @(posedge clk);
        #1;
        io.in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk_outputs_zero("mid");
        dbg_addr = 3'd3;
        #1;
        chk("mid_r3", dbg_data, 0);
        @(posedge clk);
        #1;
        chk("mid_nopulse", io.res_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        issue(ldi(2, 8'h07));
        issue(mk(0, 3, 2, 2));
        chk("post_add", io.res_data, 8'h0E);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
